hps_reset_sequencer: RTL and testbench
======================================

Name: hps_reset_sequencer

Overview:
Converts the three raw HPS reset-request levels from the in-system sources/probes (bit0 cold, bit1 warm, bit2 debug) into clean, fixed-width, active-low reset-request pulses for the HPS f2h cold/warm/debug reset-request inputs. It replaces the three independent edge-detector instances with one arbitrated sequencer. Arbitration is cold > warm > debug, one pulse in flight at a time. A post-pulse holdoff window blocks back-to-back resets. Status outputs report the last serviced request.

Parameters:
COLD_PULSE, 6, cold request low-pulse width in clk cycles (1..2^CNT_WIDTH-1)
WARM_PULSE, 2, warm request low-pulse width in clk cycles
DEBUG_PULSE, 32, debug request low-pulse width in clk cycles
HOLDOFF, 1024, cycles after a pulse during which no new pulse starts (0 allowed)
CNT_WIDTH, 11, width of the shared pulse/holdoff down-counter; must hold max(all above)

Ports:
clk  in  1  fpga_clk_50 domain
rst  in  1  asynchronous, active-high reset
req  in  3  asynchronous request levels {debug, warm, cold}; rising edge = request
cold_reset_req_n  out  1  low during cold pulse
warm_reset_req_n  out  1  low during warm pulse
debug_reset_req_n  out  1  low during debug pulse
busy  out  1  high in ASSERT or HOLDOFF
last_cause  out  2  0 none, 1 cold, 2 warm, 3 debug
req_count  out  8  serviced pulses, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Values while rst is high: all *_req_n=1, busy=0, last_cause=0, req_count=0, FSM=IDLE, pending=0, sync/prev flops=0, armed=0.
- Synchronizer: each req bit passes through a 2-flop synchronizer, then a prev flop.
- Arming: armed[i] sets the first cycle the synchronized bit is 0. Edges on unarmed bits are ignored. A level held high through reset therefore never produces a pulse.
- Edge detect: edge[i] = sync[i] & ~prev[i] & armed[i]. edge[i] sets pending[i] on the next clk.
- Cold supersedes: setting pending[0] clears pending[1] and pending[2] in the same cycle.
- FSM states: IDLE, ASSERT, HOLDOFF.
- IDLE: if pending != 0, select the highest-priority bit, clear it, load the counter with its PULSE-1, drive that output low, set last_cause, increment req_count, go to ASSERT.
- ASSERT: the output stays low. On counter == 0, release the output. If HOLDOFF > 0, load HOLDOFF-1 and go to HOLDOFF; otherwise go to IDLE.
- HOLDOFF: busy=1. New edges still set pending. On counter == 0, go to IDLE.
- Serial servicing: pending requests drain one per sequence after holdoff. Sequences are never overlapped.
- Latency: req high sampled at clk edge k gives an output low from edge k+4.
- Pulse width: exactly PULSE cycles. A minimum of 1 IDLE cycle separates sequences.
- Simultaneous edges in one cycle: all are captured. The cold clear rule applies, then warm is serviced before debug.
- Repeated edges on an already-pending bit merge into one request.
- rst mid-operation: all outputs return to reset values immediately (asynchronous). Pending requests are lost.
- Outputs are registered, glitch-free, and never more than one low at once.

Decomposition:
- Shared package hps_reset_pkg:
  - state enum {IDLE, ASSERT, HOLDOFF}
  - cause encodings CAUSE_NONE/COLD/WARM/DEBUG
  - request bit indices REQ_COLD=0, REQ_WARM=1, REQ_DEBUG=2
- One sub-module, reset_req_sync: a per-bit 2-flop synchronizer plus prev flop plus armed flag, outputting edge. Instantiate it 3 times.

Test Plan:
- rst with req=3'b001 held, release rst, hold 100 cycles -> no pulse, busy=0, req_count=0; drop req then raise -> cold_reset_req_n low 6 cycles starting 4 cycles after sample, last_cause=1, req_count=1.
- Warm edge -> warm_reset_req_n low exactly 2 cycles, busy high for 2+1024 cycles, then 0.
- Debug and warm edges in the same cycle -> warm pulse (2 cycles), 1024 holdoff, IDLE, then debug pulse (32 cycles); last_cause ends 3, req_count +2.
- Debug pending during HOLDOFF, then cold edge -> debug dropped, only cold pulse follows holdoff.
- Assert rst 3 cycles into the debug pulse -> debug_reset_req_n=1 asynchronously, busy=0, last_cause=0; no pulse after release.
- 256 serviced warm requests (HOLDOFF=0 build) -> req_count wraps to 0.

Source files
------------

// File: rtl/hps_reset_pkg.sv
// Shared types and encodings for the HPS reset-request sequencer.
// Request bit indices follow the in-system source/probe layout {debug, warm, cold}.
package hps_reset_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StHoldoff
    } state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_COLD  = 2'd1;
    localparam logic [1:0] CAUSE_WARM  = 2'd2;
    localparam logic [1:0] CAUSE_DEBUG = 2'd3;

    localparam int unsigned REQ_COLD  = 0;
    localparam int unsigned REQ_WARM  = 1;
    localparam int unsigned REQ_DEBUG = 2;

endpackage

// File: rtl/reset_req_sync.sv
// One request bit: 2-flop synchronizer, prev flop, arming flag and registered rising-edge strobe.
// A bit must be seen low after reset before any of its edges count.
module reset_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    output logic edge_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       armed_q;
    logic       armed_d;
    logic       edge_q;
    logic       edge_d;
    logic [1:0] fill_q;

    // fill_q[1] marks that sync_q holds a real sample rather than its reset value.
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~sync_q);
        edge_d  = sync_q & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            meta_q  <= req_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            armed_q <= armed_d;
            edge_q  <= edge_d;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/hps_reset_sequencer.sv
// Arbitrated sequencer turning raw cold/warm/debug request levels into fixed-width
// active-low HPS reset-request pulses, one at a time, with a post-pulse holdoff.
module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int unsigned COLD_PULSE  = 6,
    parameter int unsigned WARM_PULSE  = 2,
    parameter int unsigned DEBUG_PULSE = 32,
    parameter int unsigned HOLDOFF     = 1024,
    parameter int unsigned CNT_WIDTH   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       cold_reset_req_n,
    output logic       warm_reset_req_n,
    output logic       debug_reset_req_n,
    output logic       busy,
    output logic [1:0] last_cause,
    output logic [7:0] req_count
);

    localparam logic [CNT_WIDTH-1:0] ColdLoad  = CNT_WIDTH'(COLD_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] WarmLoad  = CNT_WIDTH'(WARM_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] DebugLoad = CNT_WIDTH'(DEBUG_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] HoldLoad  = CNT_WIDTH'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           pend_q, pend_d;
    logic [2:0]           pend_clr;
    logic [2:0]           req_n_q, req_n_d;
    logic                 busy_q, busy_d;
    logic [1:0]           cause_q, cause_d;
    logic [7:0]           count_q, count_d;
    logic [2:0]           edge_det;

    for (genvar i = 0; i < 3; i++) begin : g_sync
        reset_req_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .req_i  (req[i]),
            .edge_o (edge_det[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_clr = 3'b000;
        req_n_d  = req_n_q;
        cause_d  = cause_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
                if (pend_q != 3'b000) begin
                    state_d = StAssert;
                    count_d = count_q + 8'd1;
                    if (pend_q[REQ_COLD]) begin
                        pend_clr[REQ_COLD] = 1'b1;
                        cnt_d              = ColdLoad;
                        req_n_d            = 3'b110;
                        cause_d            = CAUSE_COLD;
                    end else if (pend_q[REQ_WARM]) begin
                        pend_clr[REQ_WARM] = 1'b1;
                        cnt_d              = WarmLoad;
                        req_n_d            = 3'b101;
                        cause_d            = CAUSE_WARM;
                    end else begin
                        pend_clr[REQ_DEBUG] = 1'b1;
                        cnt_d               = DebugLoad;
                        req_n_d             = 3'b011;
                        cause_d             = CAUSE_DEBUG;
                    end
                end
            end
            StAssert: begin
                if (cnt_q == '0) begin
                    req_n_d = 3'b111;
                    if (HOLDOFF > 0) begin
                        cnt_d   = HoldLoad;
                        state_d = StHoldoff;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                req_n_d = 3'b111;
            end
        endcase

        // A new cold request wipes out anything less severe still waiting.
        pend_d = (pend_q & ~pend_clr) | edge_det;
        if (edge_det[REQ_COLD]) begin
            pend_d[REQ_WARM]  = 1'b0;
            pend_d[REQ_DEBUG] = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 3'b000;
            req_n_q <= 3'b111;
            busy_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            req_n_q <= req_n_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign cold_reset_req_n  = req_n_q[REQ_COLD];
    assign warm_reset_req_n  = req_n_q[REQ_WARM];
    assign debug_reset_req_n = req_n_q[REQ_DEBUG];
    assign busy              = busy_q;
    assign last_cause        = cause_q;
    assign req_count         = count_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Scoreboard bench for hps_reset_sequencer: expected pulses are queued when requests are
// driven and checked (cause, start cycle, width, status) when the DUT produces them.
module tb_hps_reset_sequencer;

    typedef struct {
        int unsigned cause;
        int unsigned width;
        int unsigned start;
        int unsigned count;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b001;
    logic       cold_n, warm_n, debug_n, busy;
    logic [1:0] last_cause;
    logic [7:0] req_count;

    logic [2:0] req2 = 3'b000;
    logic       cold2_n, warm2_n, debug2_n, busy2;
    logic [1:0] last_cause2;
    logic [7:0] req_count2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned exp_count = 0;
    exp_t        sb[$];

    hps_reset_sequencer u_dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .cold_reset_req_n  (cold_n),
        .warm_reset_req_n  (warm_n),
        .debug_reset_req_n (debug_n),
        .busy              (busy),
        .last_cause        (last_cause),
        .req_count         (req_count)
    );

    hps_reset_sequencer #(
        .HOLDOFF (0)
    ) u_dut_nohold (
        .clk               (clk),
        .rst               (rst),
        .req               (req2),
        .cold_reset_req_n  (cold2_n),
        .warm_reset_req_n  (warm2_n),
        .debug_reset_req_n (debug2_n),
        .busy              (busy2),
        .last_cause        (last_cause2),
        .req_count         (req_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned cause, input int unsigned width,
                            input int unsigned start);
        exp_t e;
        exp_count  = (exp_count + 1) % 256;
        e.cause = cause;
        e.width = width;
        e.start = start;
        e.count = exp_count;
        sb.push_back(e);
    endtask

    // Raise request bits at a negedge, hold them 3 cycles, then drop them.
    task automatic pulse_req(input logic [2:0] bits);
        req = req | bits;
        repeat (3) @(negedge clk);
        req = req & ~bits;
    endtask

    // Wait until busy has been low for 4 consecutive samples, bounded by budget.
    task automatic wait_idle(input int unsigned budget);
        int unsigned quiet = 0;
        int unsigned n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        check_eq("settle", quiet, 4);
    endtask

    // Pulse monitor on the main instance.
    logic [2:0]  lows;
    logic [2:0]  act_lows = 3'b000;
    bit          active   = 1'b0;
    int unsigned run      = 0;
    int unsigned w_exp    = 0;
    int unsigned seen_cause;
    exp_t        cur;

    always @(negedge clk) begin
        lows = ~{debug_n, warm_n, cold_n};
        if (rst) begin
            active = 1'b0;
        end else if (!active && lows != 3'b000) begin
            seen_cause = (lows == 3'b001) ? 1 : (lows == 3'b010) ? 2 : (lows == 3'b100) ? 3 : 0;
            check_eq("one_low", $countones(lows), 1);
            check_eq("busy_in_pulse", busy, 1);
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", seen_cause, 0);
                w_exp = 0;
            end else begin
                cur = sb.pop_front();
                check_eq("pulse_cause", seen_cause, cur.cause);
                check_eq("pulse_start", cyc, cur.start);
                check_eq("pulse_last_cause", last_cause, cur.cause);
                check_eq("pulse_req_count", req_count, cur.count);
                w_exp = cur.width;
            end
            active   = 1'b1;
            act_lows = lows;
            run      = 1;
        end else if (active) begin
            if (lows == act_lows) begin
                run++;
            end else begin
                check_eq("pulse_width", run, w_exp);
                active = 1'b0;
            end
        end
    end

    int unsigned c0;
    int unsigned n;

    initial begin
        // Reset with cold level held high.
        repeat (3) @(negedge clk);
        check_eq("rst_cold_n", cold_n, 1);
        check_eq("rst_warm_n", warm_n, 1);
        check_eq("rst_debug_n", debug_n, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_last_cause", last_cause, 0);
        check_eq("rst_req_count", req_count, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("held_busy", busy, 0);
        check_eq("held_req_count", req_count, 0);

        // Drop then raise cold.
        req = 3'b000;
        repeat (5) @(negedge clk);
        push_exp(1, 6, cyc + 5);
        pulse_req(3'b001);
        wait_idle(3000);
        check_eq("cold_last_cause", last_cause, 1);
        check_eq("cold_req_count", req_count, 1);

        // Warm alone: 2-cycle pulse, busy for 2 + 1024 cycles.
        push_exp(2, 2, cyc + 5);
        req = 3'b010;
        repeat (4) @(negedge clk);
        req = 3'b000;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check_eq("warm_busy_len", n, 1026);
        wait_idle(3000);

        // Warm and debug in the same cycle: warm first, debug after holdoff.
        c0 = cyc;
        push_exp(2, 2, c0 + 5);
        push_exp(3, 32, c0 + 5 + 2 + 1024 + 1);
        pulse_req(3'b110);
        wait_idle(3000);
        wait_idle(3000);
        check_eq("wd_last_cause", last_cause, 3);
        check_eq("wd_req_count", req_count, 4);

        // Debug pending during holdoff is dropped by a later cold edge.
        c0 = cyc;
        push_exp(2, 2, c0 + 5);
        push_exp(1, 6, c0 + 5 + 2 + 1024 + 1);
        pulse_req(3'b010);
        repeat (20) @(negedge clk);
        pulse_req(3'b100);
        repeat (5) @(negedge clk);
        pulse_req(3'b001);
        wait_idle(3000);
        wait_idle(3000);
        check_eq("cd_last_cause", last_cause, 1);
        check_eq("cd_req_count", req_count, 6);
        check_eq("sb_drained", sb.size(), 0);

        // Reset 3 cycles into a debug pulse, debug level held through reset.
        push_exp(3, 32, cyc + 5);
        req = 3'b100;
        repeat (8) @(negedge clk);
        check_eq("dbg_low_before_rst", debug_n, 0);
        #1 rst = 1'b1;
        #1;
        check_eq("async_debug_n", debug_n, 1);
        check_eq("async_busy", busy, 0);
        check_eq("async_last_cause", last_cause, 0);
        check_eq("async_req_count", req_count, 0);
        exp_count = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_req_count", req_count, 0);
        check_eq("post_rst_sb", sb.size(), 0);
        req = 3'b000;

        // No-holdoff instance: 256 warm requests wrap the counter.
        for (int i = 0; i < 256; i++) begin
            req2[1] = 1'b1;
            repeat (4) @(negedge clk);
            req2[1] = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 0) check_eq("wrap_first", req_count2, 1);
            if (i == 254) check_eq("wrap_255", req_count2, 255);
        end
        repeat (8) @(negedge clk);
        check_eq("wrap_zero", req_count2, 0);
        check_eq("wrap_last_cause", last_cause2, 2);
        check_eq("wrap_busy", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
